// File: rtl/mode_scheduler.sv
// mode_scheduler: central hood mode sequencer with fixed-priority request arbitration,
// legal-transition enforcement and timed hurricane / self-clean / exit-delay phases.
`default_nettype none

module mode_scheduler #(
   parameter int MODE_WIDTH  = 8,
   parameter int TICK_CYCLES = 100000000,
   parameter int THIRD_TIME  = 60,
   parameter int CLEAN_TIME  = 180,
   parameter int EXIT_DELAY  = 60
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  req_off,
   input  logic                  req_stand,
   input  logic                  req_first,
   input  logic                  req_second,
   input  logic                  req_third,
   input  logic                  req_clean,
   input  logic                  req_set,
   output logic [MODE_WIDTH-1:0] current_mode,
   output logic [7:0]            countdown,
   output logic                  countdown_active,
   output logic                  third_used,
   output logic                  reject,
   output logic                  done
);

   localparam logic [2:0] c_OFF    = 3'd0;
   localparam logic [2:0] c_STAND  = 3'd1;
   localparam logic [2:0] c_FIRST  = 3'd2;
   localparam logic [2:0] c_SECOND = 3'd3;
   localparam logic [2:0] c_THIRD  = 3'd4;
   localparam logic [2:0] c_CLEAN  = 3'd5;
   localparam logic [2:0] c_SET    = 3'd6;

   localparam int             c_CW        = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
   localparam logic [c_CW-1:0] c_TICK_LAST = c_CW'(TICK_CYCLES - 1);

   logic [2:0]      r_mode;
   logic [7:0]      r_cd;
   logic            r_act;
   logic            r_pend;
   logic            r_used;
   logic            r_rej;
   logic            r_done;
   logic [c_CW-1:0] r_tcnt;

   logic            w_req_any;
   logic [2:0]      w_req;
   logic            w_legal;
   logic            w_ignore;
   logic [2:0]      w_mode;
   logic [7:0]      w_cd;
   logic            w_act;
   logic            w_pend;
   logic            w_used;
   logic            w_rej;
   logic            w_done;
   logic [c_CW-1:0] w_tcnt;

   // Fixed priority: off > stand > first > second > third > clean > set.
   always_comb begin
      w_req_any = 1'b1;
      w_req     = c_OFF;
      if (req_off)         w_req = c_OFF;
      else if (req_stand)  w_req = c_STAND;
      else if (req_first)  w_req = c_FIRST;
      else if (req_second) w_req = c_SECOND;
      else if (req_third)  w_req = c_THIRD;
      else if (req_clean)  w_req = c_CLEAN;
      else if (req_set)    w_req = c_SET;
      else                 w_req_any = 1'b0;
   end

   always_comb begin
      w_legal = 1'b0;
      case (r_mode)
         c_OFF:    w_legal = (w_req == c_STAND);
         c_STAND:  w_legal = (w_req == c_OFF) || (w_req == c_FIRST) || (w_req == c_SECOND) ||
                             (w_req == c_CLEAN) || (w_req == c_SET) ||
                             ((w_req == c_THIRD) && !r_used);
         c_FIRST:  w_legal = (w_req == c_OFF) || (w_req == c_STAND) || (w_req == c_SECOND);
         c_SECOND: w_legal = (w_req == c_OFF) || (w_req == c_STAND) || (w_req == c_FIRST);
         c_THIRD:  w_legal = (w_req == c_OFF) || ((w_req == c_STAND) && !r_pend);
         default:  w_legal = (w_req == c_OFF) || (w_req == c_STAND);
      endcase
      // Re-requesting the current mode, or repeating a deferred exit, is silently dropped.
      w_ignore = (w_req == r_mode) || ((r_mode == c_THIRD) && (w_req == c_STAND) && r_pend);
   end

   always_comb begin
      w_mode = r_mode;
      w_cd   = r_cd;
      w_act  = r_act;
      w_pend = r_pend;
      w_used = r_used;
      w_tcnt = r_tcnt;
      w_rej  = 1'b0;
      w_done = 1'b0;

      if (r_act) begin
         if (r_tcnt == c_TICK_LAST) begin
            w_tcnt = '0;
            w_cd   = r_cd - 8'd1;
            if (r_cd == 8'd1) begin
               w_act  = 1'b0;
               w_done = 1'b1;
               w_pend = 1'b0;
               w_mode = ((r_mode == c_THIRD) && !r_pend) ? c_SECOND : c_STAND;
            end
         end else begin
            w_tcnt = r_tcnt + 1'b1;
         end
      end

      // A legal request overrides any expiry computed above in the same cycle.
      if (w_req_any && w_legal) begin
         w_done = 1'b0;
         w_tcnt = '0;
         w_pend = 1'b0;
         w_cd   = 8'd0;
         w_act  = 1'b0;
         w_mode = w_req;
         if (w_req == c_OFF) begin
            w_used = 1'b0;
         end else if (w_req == c_THIRD) begin
            w_used = 1'b1;
            w_cd   = 8'(THIRD_TIME);
            w_act  = 1'b1;
         end else if (w_req == c_CLEAN) begin
            w_cd   = 8'(CLEAN_TIME);
            w_act  = 1'b1;
         end else if ((w_req == c_STAND) && (r_mode == c_THIRD)) begin
            w_mode = c_THIRD;
            w_cd   = 8'(EXIT_DELAY);
            w_act  = 1'b1;
            w_pend = 1'b1;
         end
      end else if (w_req_any && !w_ignore) begin
         w_rej = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_mode <= c_OFF;
         r_cd   <= 8'd0;
         r_act  <= 1'b0;
         r_pend <= 1'b0;
         r_used <= 1'b0;
         r_rej  <= 1'b0;
         r_done <= 1'b0;
         r_tcnt <= '0;
      end else begin
         r_mode <= w_mode;
         r_cd   <= w_cd;
         r_act  <= w_act;
         r_pend <= w_pend;
         r_used <= w_used;
         r_rej  <= w_rej;
         r_done <= w_done;
         r_tcnt <= w_tcnt;
      end
   end

   assign current_mode     = MODE_WIDTH'(r_mode);
   assign countdown        = r_cd;
   assign countdown_active = r_act;
   assign third_used       = r_used;
   assign reject           = r_rej;
   assign done             = r_done;

endmodule

`default_nettype wire

// File: tb/tb_mode_scheduler.sv
// tb_mode_scheduler: directed vectors against hand-computed mode/countdown/event values.
`default_nettype none

module tb_mode_scheduler;

   logic       clk = 1'b0;
   logic       rstn = 1'b0;
   logic       req_off = 1'b0, req_stand = 1'b0, req_first = 1'b0, req_second = 1'b0;
   logic       req_third = 1'b0, req_clean = 1'b0, req_set = 1'b0;
   logic [7:0] current_mode;
   logic [7:0] countdown;
   logic       countdown_active, third_used, reject, done;

   int n_vec = 0;
   int n_err = 0;

   mode_scheduler #(
      .MODE_WIDTH(8), .TICK_CYCLES(10), .THIRD_TIME(3), .CLEAN_TIME(2), .EXIT_DELAY(4)
   ) u_dut (
      .clk(clk), .rstn(rstn),
      .req_off(req_off), .req_stand(req_stand), .req_first(req_first),
      .req_second(req_second), .req_third(req_third), .req_clean(req_clean),
      .req_set(req_set),
      .current_mode(current_mode), .countdown(countdown),
      .countdown_active(countdown_active), .third_used(third_used),
      .reject(reject), .done(done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
      end
   endtask

   task automatic wait_n(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Drive a one-cycle request vector {off,stand,first,second,third,clean,set}; returns at
   // the negedge after the capturing posedge so registered results are visible.
   task automatic pulse(input logic [6:0] v);
      @(negedge clk);
      {req_off, req_stand, req_first, req_second, req_third, req_clean, req_set} = v;
      @(negedge clk);
      {req_off, req_stand, req_first, req_second, req_third, req_clean, req_set} = 7'b0;
   endtask

   localparam logic [6:0] c_OFF   = 7'b1000000;
   localparam logic [6:0] c_STAND = 7'b0100000;
   localparam logic [6:0] c_FIRST = 7'b0010000;
   localparam logic [6:0] c_THIRD = 7'b0000100;
   localparam logic [6:0] c_CLEAN = 7'b0000010;
   localparam logic [6:0] c_SET   = 7'b0000001;

   initial begin
      wait_n(2);
      check("rst_mode", current_mode, 0);
      check("rst_cd", countdown, 0);
      check("rst_act", countdown_active, 0);
      check("rst_used", third_used, 0);
      @(negedge clk) rstn = 1'b1;

      // Hurricane run: 0 -> 1 -> 4, countdown 3/2/1, expiry to SECOND after 30 cycles.
      pulse(c_STAND);
      check("stand_mode", current_mode, 1);
      pulse(c_THIRD);
      check("third_mode", current_mode, 4);
      check("third_cd", countdown, 3);
      check("third_act", countdown_active, 1);
      check("third_used", third_used, 1);
      wait_n(9);
      check("third_cd_n9", countdown, 3);
      wait_n(1);
      check("third_cd_n10", countdown, 2);
      wait_n(10);
      check("third_cd_n20", countdown, 1);
      wait_n(9);
      check("third_mode_n29", current_mode, 4);
      check("third_done_n29", done, 0);
      wait_n(1);
      check("exp_mode", current_mode, 3);
      check("exp_done", done, 1);
      check("exp_cd", countdown, 0);
      check("exp_act", countdown_active, 0);
      wait_n(1);
      check("exp_done_clr", done, 0);

      // Hurricane lockout until power-off.
      pulse(c_STAND);
      check("sec_to_stand", current_mode, 1);
      pulse(c_THIRD);
      check("lock_rej", reject, 1);
      check("lock_mode", current_mode, 1);
      check("lock_used", third_used, 1);
      wait_n(1);
      check("lock_rej_clr", reject, 0);
      pulse(c_OFF);
      check("off_mode", current_mode, 0);
      check("off_used", third_used, 0);
      pulse(c_STAND);
      pulse(c_THIRD);
      check("rearm_mode", current_mode, 4);

      // Deferred exit: stand at countdown 2 reloads to 4, returns to STAND 40 cycles later.
      wait_n(10);
      check("defer_cd_pre", countdown, 2);
      pulse(c_STAND);
      check("defer_mode", current_mode, 4);
      check("defer_cd", countdown, 4);
      check("defer_rej", reject, 0);
      pulse(c_STAND);
      check("defer2_rej", reject, 0);
      check("defer2_cd", countdown, 4);
      wait_n(37);
      check("defer_mode_n39", current_mode, 4);
      check("defer_cd_n39", countdown, 1);
      wait_n(1);
      check("defer_exp_mode", current_mode, 1);
      check("defer_exp_done", done, 1);

      // Priority: off beats first and clean; illegal clean from FIRST.
      pulse(c_OFF | c_FIRST | c_CLEAN);
      check("prio_mode", current_mode, 0);
      check("prio_rej", reject, 0);
      pulse(c_STAND);
      pulse(c_FIRST);
      check("first_mode", current_mode, 2);
      pulse(c_CLEAN);
      check("first_clean_rej", reject, 1);
      check("first_clean_mode", current_mode, 2);
      pulse(c_STAND);

      // Clean expiry collides with a legal stand: stand wins, no done.
      pulse(c_CLEAN);
      check("clean_mode", current_mode, 5);
      check("clean_cd", countdown, 2);
      wait_n(18);
      check("clean_cd_n18", countdown, 1);
      pulse(c_STAND);
      check("clean_st_mode", current_mode, 1);
      check("clean_st_done", done, 0);
      check("clean_st_cd", countdown, 0);

      // Clean expiry collides with an illegal set: reject and done together.
      pulse(c_CLEAN);
      wait_n(18);
      pulse(c_SET);
      check("clean_set_rej", reject, 1);
      check("clean_set_done", done, 1);
      check("clean_set_mode", current_mode, 1);

      // Asynchronous reset mid-clean with hurricane already used.
      pulse(c_THIRD);
      wait_n(30);
      check("pre_rst_mode", current_mode, 3);
      pulse(c_STAND);
      pulse(c_CLEAN);
      check("pre_rst_clean", current_mode, 5);
      check("pre_rst_used", third_used, 1);
      wait_n(5);
      #1 rstn = 1'b0;
      #1;
      check("arst_mode", current_mode, 0);
      check("arst_cd", countdown, 0);
      check("arst_act", countdown_active, 0);
      check("arst_used", third_used, 0);
      check("arst_done", done, 0);
      check("arst_rej", reject, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/mode_scheduler.md
Name: mode_scheduler

Overview:
- Central mode sequencer for the exhaust hood.
- Takes one-cycle mode-request pulses from the per-mode controllers, arbitrates simultaneous requests by fixed priority, and enforces the legal transition table.
- Runs the timed phases: hurricane (third) run limit, self-clean duration, and the delayed return from hurricane to standby.
- Drives current_mode, countdown value and event pulses to display, buzzer and lighting logic.

Parameters:
- MODE_WIDTH, 8, width of current_mode.
- TICK_CYCLES, 100000000, clk cycles per 1 s tick; the bench uses 10.
- THIRD_TIME, 60, hurricane run time in seconds (1..255).
- CLEAN_TIME, 180, self-clean duration in seconds (1..255).
- EXIT_DELAY, 60, hurricane-to-standby delay in seconds (1..255).

Ports:
- clk  in  1  system clock.
- rstn  in  1  asynchronous active-low reset.
- req_off  in  1  power-off request pulse.
- req_stand  in  1  standby request pulse.
- req_first  in  1  first-speed request pulse.
- req_second  in  1  second-speed request pulse.
- req_third  in  1  hurricane request pulse.
- req_clean  in  1  self-clean request pulse.
- req_set  in  1  settings request pulse.
- current_mode  out  MODE_WIDTH  registered mode code: OFF=0, STAND=1, FIRST=2, SECOND=3, THIRD=4, CLEAN=5, SET=6.
- countdown  out  8  remaining seconds of the active timed phase; 0 when idle.
- countdown_active  out  1  a timed phase is running.
- third_used  out  1  hurricane already used since last power-on.
- reject  out  1  one-cycle pulse: the winning request was illegal in the current mode.
- done  out  1  one-cycle pulse when a timed phase expires.

Behaviour:
- Reset (asynchronous, active-low): current_mode=OFF, countdown=0, countdown_active=0, third_used=0, reject=0, done=0, tick counter=0. Reset mid-countdown abandons the phase.
- Arbitration: each cycle, the highest-priority asserted request wins; lower ones are dropped, not queued. Priority: off > stand > first > second > third > clean > set.
- Mode changes register one cycle after the request pulse. Latency is 1 cycle.
- Legal transitions:
  - OFF: stand.
  - STAND: off, first, second, third (only if third_used=0), clean, set.
  - FIRST: off, stand, second.
  - SECOND: off, stand, first.
  - THIRD: off, stand (deferred, see below).
  - CLEAN: off, stand (aborts the clean).
  - SET: off, stand.
- A winning request that is not legal in the current mode:
  - current_mode is held and reject pulses for 1 cycle.
  - A request for the already-current mode is ignored with no reject.
- Entering THIRD: third_used<=1, countdown<=THIRD_TIME, countdown_active<=1, tick counter cleared.
- Entering CLEAN: countdown<=CLEAN_TIME, countdown_active<=1, tick counter cleared.
- req_stand in THIRD:
  - Mode stays THIRD; countdown reloads to EXIT_DELAY, tick counter cleared, exit_pending<=1.
  - A further req_stand while exit_pending=1 is ignored with no reject.
- Tick: counter runs only while countdown_active. At TICK_CYCLES-1 it wraps to 0 and countdown decrements. The first decrement occurs exactly TICK_CYCLES cycles after phase entry.
- Expiry on the tick that takes countdown from 1 to 0:
  - countdown_active<=0 and done pulses 1 cycle.
  - THIRD with exit_pending=0 goes to SECOND.
  - THIRD with exit_pending=1 goes to STAND.
  - CLEAN goes to STAND.
- Leaving a timed mode by any request: countdown<=0, countdown_active<=0, exit_pending<=0, and no done pulse.
- Simultaneous request and expiry in the same cycle:
  - A legal request wins and expiry is discarded (no done).
  - An illegal request pulses reject and expiry proceeds normally.
- Entering OFF clears third_used, countdown, countdown_active and exit_pending.
- third_used is not cleared by STAND or any other mode.

Test Plan:
- Reset, then req_stand, then req_third with TICK_CYCLES=10, THIRD_TIME=3 -> mode 0->1->4; countdown 3,2,1 at 10-cycle steps; at 30 cycles after entry mode=3, done=1 for 1 cycle, countdown=0.
- STAND, req_third after a prior hurricane use -> reject=1 for 1 cycle, mode stays 1, third_used=1. Then req_off, req_stand, req_third -> mode=4 accepted.
- THIRD at countdown=2, req_stand with EXIT_DELAY=4 -> mode stays 4, countdown=4. A second req_stand is ignored with no reject. Mode=1 exactly 40 cycles later, done=1.
- Same-cycle req_off, req_first and req_clean in STAND -> mode=0 and reject=0. In FIRST, req_clean -> reject=1, mode stays 2.
- CLEAN with CLEAN_TIME=2: req_stand on the expiry cycle -> mode=1, done stays 0. Rerun with req_set on the expiry cycle -> reject=1, done=1, mode=1.
- Assert rstn=0 mid-CLEAN countdown -> all outputs return to reset values immediately, mode=0, third_used=0.
